// File: rtl/counter_modulo8_monitor.sv
// Synchronous monitor for an asynchronous ripple mod-N counter: synchronizes and de-glitches the
// Q bits, publishes the accepted count with step/wrap pulses, and flags illegal transitions.
module counter_modulo8_monitor #(
   parameter int unsigned WIDTH         = 3,
   parameter int unsigned MODULUS       = 8,
   parameter int unsigned STABLE_CYCLES = 2
) (
   input  logic             clockpulse,
   input  logic             clear_,
   input  logic [WIDTH-1:0] signal_d,
   output logic [WIDTH-1:0] signal_value,
   output logic             signal_valid,
   output logic             signal_step,
   output logic             signal_wrap,
   output logic             signal_skip,
   output logic [7:0]       signal_wraps
);

   localparam int unsigned      RunW      = $clog2(STABLE_CYCLES + 2);
   localparam logic [RunW-1:0]  RunStable = RunW'(STABLE_CYCLES);
   localparam logic [RunW-1:0]  RunMax    = RunW'(STABLE_CYCLES + 1);
   localparam logic [WIDTH:0]   ModLim    = (WIDTH + 1)'(MODULUS);
   localparam logic [WIDTH-1:0] MaxVal    = WIDTH'(MODULUS - 1);

   typedef enum logic [0:0] {StInit, StTrack} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] s1_q, s2_q;
   logic [RunW-1:0]  run_q, run_d;
   logic [WIDTH-1:0] value_q, value_d;
   logic             valid_q, valid_d;
   logic             step_q, step_d;
   logic             wrap_q, wrap_d;
   logic             skip_q, skip_d;
   logic [7:0]       wraps_q, wraps_d;

   logic             cand_ready;
   logic             cand_in_range;
   logic [WIDTH-1:0] next_value;

   // The run counter saturates one past the threshold so each candidate is evaluated only once.
   assign cand_ready    = (run_q == RunStable);
   assign cand_in_range = ({1'b0, s2_q} < ModLim);
   assign next_value    = (value_q == MaxVal) ? '0 : value_q + WIDTH'(1);

   always_ff @(posedge clockpulse) begin
      if (!clear_) begin
         state_q <= StInit;
         s1_q    <= '0;
         s2_q    <= '0;
         run_q   <= '0;
         value_q <= '0;
         valid_q <= 1'b0;
         step_q  <= 1'b0;
         wrap_q  <= 1'b0;
         skip_q  <= 1'b0;
         wraps_q <= '0;
      end else begin
         state_q <= state_d;
         s1_q    <= signal_d;
         s2_q    <= s1_q;
         run_q   <= run_d;
         value_q <= value_d;
         valid_q <= valid_d;
         step_q  <= step_d;
         wrap_q  <= wrap_d;
         skip_q  <= skip_d;
         wraps_q <= wraps_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (cand_ready && state_q == StInit && cand_in_range) begin
         state_d = StTrack;
      end
   end

   always_comb begin
      run_d   = run_q;
      value_d = value_q;
      valid_d = valid_q;
      step_d  = 1'b0;
      wrap_d  = 1'b0;
      skip_d  = skip_q;
      wraps_d = wraps_q;

      if (s1_q != s2_q) begin
         run_d = RunW'(1);
      end else if (run_q != RunMax) begin
         run_d = run_q + RunW'(1);
      end

      if (cand_ready) begin
         unique case (state_q)
            StInit: begin
               if (cand_in_range) begin
                  value_d = s2_q;
                  valid_d = 1'b1;
               end
            end
            StTrack: begin
               if (!cand_in_range) begin
                  skip_d = 1'b1;
               end else if (s2_q != value_q) begin
                  value_d = s2_q;
                  if (s2_q == next_value) begin
                     step_d = 1'b1;
                     if (value_q == MaxVal) begin
                        wrap_d = 1'b1;
                        if (wraps_q != 8'hff) begin
                           wraps_d = wraps_q + 8'd1;
                        end
                     end
                  end else begin
                     skip_d = 1'b1;
                  end
               end
            end
         endcase
      end
   end

   assign signal_value = value_q;
   assign signal_valid = valid_q;
   assign signal_step  = step_q;
   assign signal_wrap  = wrap_q;
   assign signal_skip  = skip_q;
   assign signal_wraps = wraps_q;

endmodule

// File: tb/tb_counter_modulo8_monitor.sv
// Randomized self-checking bench: a sample-history model of the monitor is compared against the
// DUT after every clock, plus literal checkpoints for the directed scenarios.
module tb_counter_modulo8_monitor;

   localparam int WIDTH   = 3;
   localparam int MODULUS = 8;
   localparam int STABLE  = 2;

   logic             clockpulse = 1'b0;
   logic             clear_     = 1'b0;
   logic [WIDTH-1:0] signal_d   = '0;
   logic [WIDTH-1:0] signal_value;
   logic             signal_valid;
   logic             signal_step;
   logic             signal_wrap;
   logic             signal_skip;
   logic [7:0]       signal_wraps;

   counter_modulo8_monitor #(
      .WIDTH         (WIDTH),
      .MODULUS       (MODULUS),
      .STABLE_CYCLES (STABLE)
   ) dut (
      .clockpulse   (clockpulse),
      .clear_       (clear_),
      .signal_d     (signal_d),
      .signal_value (signal_value),
      .signal_valid (signal_valid),
      .signal_step  (signal_step),
      .signal_wrap  (signal_wrap),
      .signal_skip  (signal_skip),
      .signal_wraps (signal_wraps)
   );

   always #5 clockpulse = ~clockpulse;

   int n_checks = 0;
   int n_pass   = 0;
   int step_cnt = 0;
   int wrap_cnt = 0;

   // Reference model state
   int m_value, m_valid, m_step, m_wrap, m_skip, m_wraps;
   int p1, p2, cand;
   bit pend;
   int hist[$];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
   endtask

   // Length of the current run of identical synchronized samples since reset.
   function automatic int trailing_run();
      int r = 0;
      for (int i = hist.size() - 1; i >= 0; i--) begin
         if (hist[i] != hist[hist.size() - 1] || r > STABLE) break;
         r++;
      end
      return r;
   endfunction

   task automatic evaluate(input int c);
      if (m_valid == 0) begin
         if (c < MODULUS) begin
            m_value = c;
            m_valid = 1;
         end
      end else if (c >= MODULUS) begin
         m_skip = 1;
      end else if (c != m_value) begin
         if (c == (m_value + 1) % MODULUS) begin
            m_step = 1;
            if (m_value == MODULUS - 1) begin
               m_wrap  = 1;
               m_wraps = (m_wraps < 255) ? m_wraps + 1 : 255;
            end
         end else begin
            m_skip = 1;
         end
         m_value = c;
      end
   endtask

   task automatic model_step(input bit rst_n, input int d);
      if (!rst_n) begin
         m_value = 0; m_valid = 0; m_step = 0; m_wrap = 0; m_skip = 0; m_wraps = 0;
         p1 = 0; p2 = 0; cand = 0; pend = 0;
         hist.delete();
      end else begin
         m_step = 0;
         m_wrap = 0;
         if (pend) evaluate(cand);
         p2 = p1;
         p1 = d;
         hist.push_back(p2);
         if (hist.size() > 32) void'(hist.pop_front());
         pend = (trailing_run() == STABLE);
         cand = p2;
      end
   endtask

   always @(posedge clockpulse) begin
      model_step(clear_, int'(signal_d));
      #1;
      check("value", int'(signal_value), m_value);
      check("valid", int'(signal_valid), m_valid);
      check("step",  int'(signal_step),  m_step);
      check("wrap",  int'(signal_wrap),  m_wrap);
      check("skip",  int'(signal_skip),  m_skip);
      check("wraps", int'(signal_wraps), m_wraps);
      step_cnt += int'(signal_step);
      wrap_cnt += int'(signal_wrap);
   end

   task automatic hold(input int v, input int n);
      signal_d = v[WIDTH-1:0];
      repeat (n) @(negedge clockpulse);
   endtask

   task automatic pulse_reset(input int v);
      clear_ = 1'b0;
      hold(v, 1);
      clear_ = 1'b1;
   endtask

   initial begin
      int v;
      // Reset with a non-zero input present
      clear_ = 1'b0;
      signal_d = 3'd5;
      repeat (2) @(negedge clockpulse);
      check("t1_value", int'(signal_value), 0);
      check("t1_valid", int'(signal_valid), 0);
      check("t1_flags", int'({signal_step, signal_wrap, signal_skip}), 0);
      check("t1_wraps", int'(signal_wraps), 0);

      // First load: accepted on edge 4, no event
      clear_ = 1'b1;
      step_cnt = 0;
      hold(3, 3);
      check("t2_valid_early", int'(signal_valid), 0);
      hold(3, 1);
      check("t2_value", int'(signal_value), 3);
      check("t2_valid", int'(signal_valid), 1);
      check("t2_model", m_value, 3);
      hold(3, 3);
      check("t2_nostep", step_cnt, 0);
      check("t2_skip", int'(signal_skip), 0);

      // Full sweep with one wrap
      pulse_reset(0);
      step_cnt = 0;
      wrap_cnt = 0;
      for (int i = 0; i <= 8; i++) hold(i % 8, 6);
      check("t3_steps", step_cnt, 8);
      check("t3_wrappulses", wrap_cnt, 1);
      check("t3_wraps", int'(signal_wraps), 1);
      check("t3_skip", int'(signal_skip), 0);
      check("t3_model_wraps", m_wraps, 1);

      // Ripple transients between 3 and 4
      hold(1, 6);
      hold(2, 6);
      hold(3, 6);
      step_cnt = 0;
      hold(2, 1);
      hold(0, 1);
      hold(4, 6);
      check("t4_steps", step_cnt, 1);
      check("t4_value", int'(signal_value), 4);
      check("t4_skip", int'(signal_skip), 0);

      // Illegal jump, then a legal step with sticky skip
      pulse_reset(2);
      hold(2, 6);
      step_cnt = 0;
      hold(6, 6);
      check("t5_skip", int'(signal_skip), 1);
      check("t5_value", int'(signal_value), 6);
      check("t5_nostep", step_cnt, 0);
      hold(7, 6);
      check("t5_step", step_cnt, 1);
      check("t5_skip_sticky", int'(signal_skip), 1);

      // Wrap counter saturation
      for (int k = 0; k < 300; k++) begin
         for (int j = 0; j < 8; j++) hold(j, 3);
      end
      check("t6_wraps_sat", int'(signal_wraps), 255);
      check("t6_model_sat", m_wraps, 255);

      // Reset in the middle of filtering
      hold(0, 2);
      clear_ = 1'b0;
      hold(1, 1);
      check("t6_rst_value", int'(signal_value), 0);
      check("t6_rst_valid", int'(signal_valid), 0);
      check("t6_rst_flags", int'({signal_step, signal_wrap, signal_skip}), 0);
      check("t6_rst_wraps", int'(signal_wraps), 0);
      clear_ = 1'b1;

      // Randomized traffic: mostly counting, with glitches, jumps and occasional resets
      v = 0;
      for (int i = 0; i < 600; i++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 2) begin
            pulse_reset(int'($urandom_range(0, 7)));
         end else begin
            if (r < 15) v = int'($urandom_range(0, 7));
            else v = (v + 1) % MODULUS;
            hold(v, int'($urandom_range(1, 5)));
         end
      end
      hold(v, 6);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
